idct8_1d_pipe: RTL
==================

// Module: idct8_1d_pipe
// PURPOSE
// - Pipelined 8-point 1D inverse integer DCT (HEVC coefficients 64/89/83/75/50/36/18).
// - Inverse partner of the combinational 8-point forward DCT: takes one coefficient vector per beat and returns 8 spatial samples.
// - Rounds, shifts and narrows the result.
// - Sits in the column/row passes of the 2D IDCT, between the transpose buffer and the pixel writeback.
// PARAMETERS
// - Y_W    18  signed coefficient width in; matches the forward-DCT output width (8-bit path).
// - X_W    16  signed sample width out.
// - SHIFT  7   post-sum right shift; rounding offset is 1<<(SHIFT-1). Legal range 1..12.
// - ACC_W  Y_W+10  internal sum width. Derived; not overridable.
// PORTS
// - clk        in   1         rising-edge clock.
// - rst        in   1         asynchronous reset, active-high.
// - in_valid   in   1         y vector valid.
// - in_ready   out  1         block accepts y this cycle.
// - y          in   8 x Y_W   signed coefficients y[0..7], with y[0] = DC.
// - out_valid  out  1         x vector valid.
// - out_ready  in   1         downstream accepts x.
// - x          out  8 x X_W   signed samples x[0..7].
// BEHAVIOUR
// - Reset: all stage valid flags are 0. out_valid=0 and x=0 when rst is asserted.
//   - in_ready is 1 from the first cycle after reset deasserts.
// - Handshake:
//   - A beat transfers when valid&&ready.
//   - Once asserted, out_valid holds and x stays stable until out_ready is seen.
//   - in_ready=!s1_v || s1_adv. A stage advances when it is empty or the stage after it advances.
//   - s3 advances when !out_valid || out_ready.
// - Latency: 3 cycles from the accept edge to out_valid, with no stall. Throughput is 1 vector per cycle.
// - Combinational paths: no combinational path from in_valid to out_valid, or from y to x. out_ready->in_ready is combinational, through the stall chain only.
// - S1 (register): multiply the coefficients by shift-add; no DSP multipliers.
//   - Even products: 64*y0, 64*y4, 83*y2, 36*y2, 83*y6, 36*y6.
//   - Odd products: 89,75,50,18 times each of y1, y3, y5, y7.
// - S2 (register): even and odd terms.
//   - EE0=64y0+64y4+83y2+36y6; EE1=64y0-64y4+36y2-83y6; EE2=64y0-64y4-36y2+83y6; EE3=64y0+64y4-83y2-36y6.
//   - O0=89y1+75y3+50y5+18y7; O1=75y1-18y3-89y5-50y7; O2=50y1-89y3+18y5+75y7; O3=18y1-50y3+75y5-89y7.
// - S3 (output register): butterfly, then round, then narrow.
//   - Butterfly: s[n]=EE[n]+O[n] and s[7-n]=EE[n]-O[n], for n=0..3.
//   - Round: r=(s+(1<<(SHIFT-1)))>>>SHIFT. This is an arithmetic shift, i.e. floor, so ties round toward +inf.
//   - Narrow: r to X_W, per CONFIGURATION.
// - Width: all intermediates are signed ACC_W, sign-extended before every add. No overflow is possible for |y|<2^(Y_W-1).
// - Simultaneous events:
//   - Accept and emit in the same cycle is legal; the pipeline shifts.
//   - A full pipeline with out_ready=0 holds all 3 stages and drops in_ready.
// - Reset mid-operation: in-flight vectors are discarded with no partial output. Data registers need not clear, except x.
// CONFIGURATION
// - IDCT8_SAT_EN defined: each r saturates to [-2^(X_W-1), 2^(X_W-1)-1].
// - IDCT8_SAT_EN undefined: x=r[X_W-1:0], i.e. two's-complement wrap. No saturation logic.
// STRUCTURE
// - Package dct_pkg holds:
//   - The coefficient localparams C64, C89, C83, C75, C50, C36, C18.
//   - The ACC_W derivation function.
//   - The typedef acc_t.
// - Sub-module idct8_odd_mac: combinational 4x4 odd sums O0..O3 from the S1 odd products. Instantiated once in S2.
// - Even path, butterfly, round/narrow and handshake stay in the top module.
// TESTING
// - DC impulse: y0=64, others 0 -> every x[n]=32 ((4096+64)>>>7), 3 cycles after accept.
// - AC1 impulse: y1=128, others 0 -> x0=89, x7=-89, x3=18, x4=-18.
// - Overflow: y0=131071, others 0.
//   - With IDCT8_SAT_EN: all x=32767.
//   - Without: all x=0 (65536 wraps).
// - Backpressure: 10 back-to-back vectors while out_ready is held 0 for cycles 4..8.
//   - in_ready drops once 3 vectors are held.
//   - No loss or duplication; order is preserved; x is stable while stalled.
// - Reset mid-stream: rst pulsed with 2 vectors in flight -> out_valid=0 next cycle, neither vector is emitted, in_ready=1 after release.
// - Random: 10k random y (full Y_W range) with random valid/ready -> bit-exact against the integer golden model, both macro settings.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared constants and types for the 8-point integer IDCT datapath.
// Holds the HEVC 8-point coefficients, the accumulator width derivation
// and the default-width accumulator type.
package dct_pkg;

  localparam logic [7:0] C64 = 8'd64;
  localparam logic [7:0] C89 = 8'd89;
  localparam logic [7:0] C83 = 8'd83;
  localparam logic [7:0] C75 = 8'd75;
  localparam logic [7:0] C50 = 8'd50;
  localparam logic [7:0] C36 = 8'd36;
  localparam logic [7:0] C18 = 8'd18;

  localparam int Y_W_DEF = 18;

  // 10 guard bits cover the largest row sum (|89|+|75|+|50|+|18| plus the
  // even half) with no overflow for any legal input.
  function automatic int acc_width(input int y_w);
    return y_w + 10;
  endfunction

  localparam int ACC_W_DEF = acc_width(Y_W_DEF);

  typedef logic signed [ACC_W_DEF-1:0] acc_t;

endpackage

// File: rtl/idct8_odd_mac.sv
// Odd-half combiner of the 8-point IDCT.
// Ports:
//   prod_i : 16 x ACC_W signed products, index k*4+c where k selects
//            y1/y3/y5/y7 and c selects coefficient 89/75/50/18.
//   odd_o  : 4 x ACC_W signed odd sums O0..O3 (O0 in the low slice).
// Purely combinational.
module idct8_odd_mac
  import dct_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [16*ACC_W-1:0] prod_i,
  output logic [4*ACC_W-1:0]  odd_o
);

  logic signed [ACC_W-1:0] p [16];
  logic signed [ACC_W-1:0] o [4];

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      p[i] = signed'(prod_i[i*ACC_W +: ACC_W]);
    end
  end

  // p[k*4+c]: k 0..3 = y1,y3,y5,y7 ; c 0..3 = 89,75,50,18
  always_comb begin
    o[0] = p[0*4+0] + p[1*4+1] + p[2*4+2] + p[3*4+3];
    o[1] = p[0*4+1] - p[1*4+3] - p[2*4+0] - p[3*4+2];
    o[2] = p[0*4+2] - p[1*4+0] + p[2*4+3] + p[3*4+1];
    o[3] = p[0*4+3] - p[1*4+2] + p[2*4+1] - p[3*4+0];
  end

  assign odd_o = {o[3], o[2], o[1], o[0]};

endmodule

// File: rtl/idct8_1d_pipe.sv
// Pipelined 8-point 1D inverse integer DCT (HEVC coefficients).
// Ports:
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake for coefficient vector y
//   y                   : 8 x Y_W signed coefficients, y[0] (DC) in low slice
//   out_valid/out_ready : output handshake for sample vector x
//   x                   : 8 x X_W signed samples, x[0] in low slice
// Stages: S1 shift-add products, S2 even/odd sums, S3 butterfly+round+narrow.
// out_valid rises on the third rising edge counting the accept edge.
// Build option: define IDCT8_SAT_EN to saturate outputs to X_W; otherwise
// the rounded result wraps to X_W bits.
module idct8_1d_pipe
  import dct_pkg::*;
#(
  parameter int Y_W   = 18,
  parameter int X_W   = 16,
  parameter int SHIFT = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8*Y_W-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8*X_W-1:0] x
);

  localparam int ACC_W = acc_width(Y_W);
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(64'sd1 <<< (SHIFT - 1));
`ifdef IDCT8_SAT_EN
  localparam logic signed [ACC_W-1:0] XMAX = ACC_W'((64'sd1 <<< (X_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] XMIN = ACC_W'(-(64'sd1 <<< (X_W - 1)));
`endif
  localparam logic [7:0] ODD_C [4] = '{C89, C75, C50, C18};

  // Constant multiply as a sum of shifted copies; c is always a constant
  // at the call site, so this folds to a fixed adder tree.
  function automatic logic signed [ACC_W-1:0] cmul(
    input logic signed [ACC_W-1:0] a,
    input logic [7:0]              c
  );
    logic signed [ACC_W-1:0] acc;
    acc = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (c[b]) acc = acc + (a <<< b);
    end
    return acc;
  endfunction

  // Handshake / stall chain
  logic s1_v_q, s1_v_d;
  logic s2_v_q, s2_v_d;
  logic s3_v_q, s3_v_d;
  logic s1_ld, s2_ld, s3_ld;

  always_comb begin
    s3_ld  = !s3_v_q || out_ready;
    s2_ld  = !s2_v_q || s3_ld;
    s1_ld  = !s1_v_q || s2_ld;
    s1_v_d = s1_ld ? in_valid : s1_v_q;
    s2_v_d = s2_ld ? s1_v_q   : s2_v_q;
    s3_v_d = s3_ld ? s2_v_q   : s3_v_q;
  end

  assign in_ready  = s1_ld;
  assign out_valid = s3_v_q;

  // S1: products
  logic signed [ACC_W-1:0] ye   [8];
  logic signed [ACC_W-1:0] ev_d [6];
  logic signed [ACC_W-1:0] ev_q [6];
  logic signed [ACC_W-1:0] od_d [16];
  logic signed [ACC_W-1:0] od_q [16];

  always_comb begin
    for (int unsigned k = 0; k < 8; k++) begin
      ye[k] = ACC_W'(signed'(y[k*Y_W +: Y_W]));
    end
    ev_d[0] = cmul(ye[0], C64);
    ev_d[1] = cmul(ye[4], C64);
    ev_d[2] = cmul(ye[2], C83);
    ev_d[3] = cmul(ye[2], C36);
    ev_d[4] = cmul(ye[6], C83);
    ev_d[5] = cmul(ye[6], C36);
    for (int unsigned k = 0; k < 4; k++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        od_d[k*4+c] = cmul(ye[2*k+1], ODD_C[c]);
      end
    end
  end

  // S2: even and odd sums
  logic signed [ACC_W-1:0] ee_d [4];
  logic signed [ACC_W-1:0] ee_q [4];
  logic signed [ACC_W-1:0] o_d  [4];
  logic signed [ACC_W-1:0] o_q  [4];
  logic [16*ACC_W-1:0]     od_flat;
  logic [4*ACC_W-1:0]      o_flat;

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      od_flat[i*ACC_W +: ACC_W] = od_q[i];
    end
  end

  idct8_odd_mac #(
    .ACC_W (ACC_W)
  ) u_odd_mac (
    .prod_i (od_flat),
    .odd_o  (o_flat)
  );

  // ev_q: 0=64y0 1=64y4 2=83y2 3=36y2 4=83y6 5=36y6
  always_comb begin
    ee_d[0] = ev_q[0] + ev_q[1] + ev_q[2] + ev_q[5];
    ee_d[1] = ev_q[0] - ev_q[1] + ev_q[3] - ev_q[4];
    ee_d[2] = ev_q[0] - ev_q[1] - ev_q[3] + ev_q[4];
    ee_d[3] = ev_q[0] + ev_q[1] - ev_q[2] - ev_q[5];
    for (int unsigned i = 0; i < 4; i++) begin
      o_d[i] = signed'(o_flat[i*ACC_W +: ACC_W]);
    end
  end

  // S3: butterfly, round (floor shift), narrow
  logic signed [ACC_W-1:0] s [8];
  logic signed [ACC_W-1:0] r [8];
  logic [8*X_W-1:0]        x_d;
  logic [8*X_W-1:0]        x_q;

  always_comb begin
    x_d = '0;
    for (int unsigned n = 0; n < 4; n++) begin
      s[n]     = ee_q[n] + o_q[n];
      s[7 - n] = ee_q[n] - o_q[n];
    end
    for (int unsigned n = 0; n < 8; n++) begin
      r[n] = (s[n] + RND) >>> SHIFT;
`ifdef IDCT8_SAT_EN
      if (r[n] > XMAX)      x_d[n*X_W +: X_W] = X_W'(XMAX);
      else if (r[n] < XMIN) x_d[n*X_W +: X_W] = X_W'(XMIN);
      else                  x_d[n*X_W +: X_W] = X_W'(r[n]);
`else
      x_d[n*X_W +: X_W] = X_W'(r[n]);
`endif
    end
  end

  assign x = x_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s3_v_q <= 1'b0;
      x_q    <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s3_v_q <= s3_v_d;
      if (s3_ld && s2_v_q) x_q <= x_d;
    end
  end

  // Data stages carry no reset; their valid flags gate every use.
  always_ff @(posedge clk) begin
    if (s1_ld && in_valid) begin
      ev_q <= ev_d;
      od_q <= od_d;
    end
    if (s2_ld && s1_v_q) begin
      ee_q <= ee_d;
      o_q  <= o_d;
    end
  end

endmodule
